ram_arbiter_rr2: RTL
====================

Name: ram_arbiter_rr2

Overview:
- Two-requester round-robin arbiter that shares one single-port synchronous-read RAM (write on clock edge, read address latched on clock edge, data valid the following cycle).
- Each requester issues single-word read/write transactions. The arbiter muxes address, data and write-enable onto the RAM, tracks the outstanding read, and returns registered read data with a valid pulse to the requester that issued the read.

Parameters:
- AWIDTH, 3, RAM address width; depth is 2**AWIDTH.
- DWIDTH, 32, data width.

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset_n  input  1  synchronous, active-low reset.
- req_a  input  1  requester A transaction request; held until granted.
- we_a  input  1  requester A: 1 = write, 0 = read; valid while req_a=1.
- addr_a  input  AWIDTH  requester A address.
- wdata_a  input  DWIDTH  requester A write data.
- gnt_a  output  1  requester A grant (combinational); transfer occurs on the edge where req_a and gnt_a are both 1.
- rvalid_a  output  1  one-cycle pulse; rdata_a is valid.
- rdata_a  output  DWIDTH  requester A read data (registered, held until next A read returns).
- req_b, we_b, addr_b, wdata_b, gnt_b, rvalid_b, rdata_b: same as the A ports, for requester B.
- ram_addr  output  AWIDTH  to RAM address.
- ram_din  output  DWIDTH  to RAM write data.
- ram_we  output  1  to RAM write enable.
- ram_dout  input  DWIDTH  from RAM read data (valid the cycle after its address was presented).

Behaviour:
- Reset (reset_n=0 at an edge):
  - last_gnt <= B, so A wins the first contention.
  - rd_pend <= 0; rvalid_a/b <= 0; rdata_a/b <= 0.
  - While reset_n=0, gnt_a = gnt_b = 0 and ram_we = 0 combinationally.
- Arbitration, combinational each cycle (reset_n=1):
  - Only req_a: gnt_a=1.
  - Only req_b: gnt_b=1.
  - Both: grant the requester not equal to last_gnt.
  - Neither: no grant.
  - gnt_a and gnt_b are never both 1.
- last_gnt updates only on an edge where a grant is given; it is unchanged in idle cycles.
- RAM drive:
  - Granted requester: ram_addr/ram_din = its addr/wdata; ram_we = its we.
  - No grant: ram_addr=0, ram_din=0, ram_we=0.
- Read tracking:
  - On an edge with a granted read: rd_pend <= 1, rd_id <= granted requester; otherwise rd_pend <= 0.
  - Next cycle (N+1) ram_dout holds the data. On the edge ending N+1, if rd_pend: rdata_<rd_id> <= ram_dout and rvalid_<rd_id> <= 1 for exactly one cycle. Other rvalid <= 0.
- Latency:
  - Read granted in cycle N gives rvalid in cycle N+2.
  - Write takes effect at the edge ending cycle N; no response.
- Throughput: one transaction per cycle. Back-to-back reads, including alternating A/B, are fully pipelined; each rvalid is routed by rd_id.
- Write-then-read, same address, consecutive cycles: the read returns the newly written data. This is a RAM property; the arbiter adds no forwarding.
- Starvation bound: with both requesting continuously, grants strictly alternate, so each requester waits at most 1 cycle.
- A requester may change addr/we/wdata only after a cycle in which it was granted. Request behaviour while not granted is outside this block's checks.
- Reset mid-operation: a pending read is dropped (no rvalid), and rdata is cleared to 0.
- Unused RAM location contents are not touched by reset.

Test Plan:
- Reset then idle: reset_n=0 for 2 cycles → all gnt/rvalid=0, rdata_a=rdata_b=0, ram_we=0. Then reset_n=1 with no req → ram_addr=0, ram_we=0.
- A alone: A writes 0xDEADBEEF to addr 5, then reads addr 5 next cycle → gnt_a=1 both cycles; rvalid_a pulses 2 cycles after the read grant with rdata_a=0xDEADBEEF; rvalid_b stays 0.
- Contention: req_a=req_b=1 for 4 cycles, all reads of addrs 1 (A) / 2 (B) preloaded 0x11/0x22 → grants A,B,A,B; rvalid_a and rvalid_b alternate from cycle 2 onward with 0x11 and 0x22 respectively.
- Fairness memory: B granted alone, idle 3 cycles, then both request → A granted first. Repeat with A last → B granted first.
- Write/read interleave: A writes 0x5 to addr 3 while B requests a read of addr 3 simultaneously (last_gnt=B) → A granted first; B read on next cycle returns 0x5.
- Reset mid-read: A read granted, reset_n=0 on the following edge → no rvalid_a, rdata_a=0, and arbitration restarts with A priority.

Source files
------------

// File: rtl/ram_arbiter_rr2.sv
// Two-requester round-robin arbiter in front of a single-port sync-read RAM.
// Routes each read response back to its issuer one cycle after RAM output.
module ram_arbiter_rr2 #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [AWIDTH-1:0] addr_a,
  input  logic [DWIDTH-1:0] wdata_a,
  output logic              gnt_a,
  output logic              rvalid_a,
  output logic [DWIDTH-1:0] rdata_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [AWIDTH-1:0] addr_b,
  input  logic [DWIDTH-1:0] wdata_b,
  output logic              gnt_b,
  output logic              rvalid_b,
  output logic [DWIDTH-1:0] rdata_b,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_din,
  output logic              ram_we,
  input  logic [DWIDTH-1:0] ram_dout
);

  typedef enum logic {SRC_A, SRC_B} src_e;

  src_e              last_q, last_d;
  src_e              rd_id_q, rd_id_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rvalid_a_q, rvalid_a_d;
  logic              rvalid_b_q, rvalid_b_d;
  logic [DWIDTH-1:0] rdata_a_q, rdata_a_d;
  logic [DWIDTH-1:0] rdata_b_q, rdata_b_d;

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (reset_n) begin
      unique case ({req_a, req_b})
        2'b10: gnt_a = 1'b1;
        2'b01: gnt_b = 1'b1;
        2'b11: begin
          gnt_a = (last_q == SRC_B);
          gnt_b = (last_q == SRC_A);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ram_addr = '0;
    ram_din  = '0;
    ram_we   = 1'b0;
    unique case (1'b1)
      gnt_a: begin
        ram_addr = addr_a;
        ram_din  = wdata_a;
        ram_we   = we_a;
      end
      gnt_b: begin
        ram_addr = addr_b;
        ram_din  = wdata_b;
        ram_we   = we_b;
      end
      default: ;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (gnt_a) last_d = SRC_A;
    else if (gnt_b) last_d = SRC_B;
    rd_pend_d  = (gnt_a & ~we_a) | (gnt_b & ~we_b);
    rd_id_d    = gnt_b ? SRC_B : SRC_A;
    // RAM data is on ram_dout the cycle after the read was issued
    rvalid_a_d = rd_pend_q & (rd_id_q == SRC_A);
    rvalid_b_d = rd_pend_q & (rd_id_q == SRC_B);
    rdata_a_d  = rvalid_a_d ? ram_dout : rdata_a_q;
    rdata_b_d  = rvalid_b_d ? ram_dout : rdata_b_q;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      last_q     <= SRC_B;
      rd_id_q    <= SRC_A;
      rd_pend_q  <= 1'b0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
    end else begin
      last_q     <= last_d;
      rd_id_q    <= rd_id_d;
      rd_pend_q  <= rd_pend_d;
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
      rdata_a_q  <= rdata_a_d;
      rdata_b_q  <= rdata_b_d;
    end
  end

  assign rvalid_a = rvalid_a_q;
  assign rvalid_b = rvalid_b_q;
  assign rdata_a  = rdata_a_q;
  assign rdata_b  = rdata_b_q;

endmodule
